// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator side of the single-port 512x32 RAM.
// Accepts one load or store at a time from the control unit and sequences
// the RAM strobes so that address/data are stable before the write strobe
// rises and remain stable after it falls. Load data is captured into a
// holding register for the MDR.
//
// Ports:
//   clk, clr            clock, asynchronous active-high reset
//   req_rd, req_wr      load / store request (sampled only in IDLE)
//   addr_in, wdata_in   word address (MAR) and store data (MDR)
//   rdata_out           last captured load data
//   busy, done, err     not-idle, completion pulse, illegal-request pulse
//   ram_read/ram_write  RAM strobes (registered, never high together)
//   ram_address         RAM address
//   ram_wdata           RAM BusMuxOut
//   ram_rdata           RAM Mdatain
module mem_access_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = 1,   // 0..15
  parameter int WR_CYC  = 1    // 1..15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [DATA_W-1:0] rdata_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_e;

  localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT = 4'(WR_CYC - 1);

  state_e              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                busy_q, done_q, err_q, rd_q, wr_q;

  // Every output is a flop updated together with the state, so strobes are
  // glitch-free and the async reset clears them in the same time step.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_rd && !req_wr) begin
            addr_q  <= addr_in;
            cnt_q   <= RD_CNT;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_RD;
          end else if (req_wr && !req_rd) begin
            addr_q  <= addr_in;
            wdata_q <= wdata_in;
            busy_q  <= 1'b1;
            state_q <= S_WR_SETUP;
          end else if (req_rd && req_wr) begin
            err_q <= 1'b1;  // ambiguous request: flag it, touch nothing
          end
        end
        S_RD: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            rdata_q <= ram_rdata;
            rd_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_WR_SETUP: begin
          cnt_q   <= WR_CNT;
          wr_q    <= 1'b1;
          state_q <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            wr_q    <= 1'b0;
            state_q <= S_WR_HOLD;
          end
        end
        S_WR_HOLD: begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rdata_out   = rdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ram_read    = rd_q;
  assign ram_write   = wr_q;
  assign ram_address = addr_q;
  assign ram_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table of load/store/illegal vectors with a
// done-time scoreboard, plus hand sequences for reset, busy and RD_WAIT=3.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_rd, req_wr;
  logic [8:0]  addr_in;
  logic [31:0] wdata_in;
  logic [31:0] rdata_out, ram_wdata, ram_rdata;
  logic        busy, done, err, ram_read, ram_write;
  logic [8:0]  ram_address;

  logic        rd3, wr3;
  logic [8:0]  addr3;
  logic [31:0] wdata3;
  logic [31:0] rdata_out3, rwdata3, rrdata3;
  logic        busy3, done3, err3, rread3, rwrite3;
  logic [8:0]  raddr3;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .clr(clr), .req_rd(req_rd), .req_wr(req_wr),
    .addr_in(addr_in), .wdata_in(wdata_in), .rdata_out(rdata_out),
    .busy(busy), .done(done), .err(err), .ram_read(ram_read),
    .ram_write(ram_write), .ram_address(ram_address),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  mem_access_ctrl #(.RD_WAIT(3)) dut3 (
    .clk(clk), .clr(clr), .req_rd(rd3), .req_wr(wr3),
    .addr_in(addr3), .wdata_in(wdata3), .rdata_out(rdata_out3),
    .busy(busy3), .done(done3), .err(err3), .ram_read(rread3),
    .ram_write(rwrite3), .ram_address(raddr3),
    .ram_wdata(rwdata3), .ram_rdata(rrdata3)
  );

  // RAM models: combinational read (Z when not reading), write on edge.
  logic [31:0] mem  [512];
  logic [31:0] mem3 [512];
  assign ram_rdata = ram_read ? mem[ram_address] : 'z;
  assign rrdata3   = rread3 ? mem3[raddr3] : 'z;
  always @(posedge clk) if (ram_write) mem[ram_address] <= ram_wdata;
  always @(posedge clk) if (rwrite3) mem3[raddr3] <= rwdata3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic [31:0] rdata;
    int          edge_n;
  } sb_t;
  sb_t sbq[$];
  sb_t e;

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = sbq.pop_front();
        check("done_edge", cyc, e.edge_n);
        check("done_rdata", rdata_out, e.rdata);
      end
    end
  end

  typedef struct {
    bit          rd;
    bit          wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          lat;
  } vec_t;
  vec_t vecs[8];

  logic [8:0]  exp_addr;
  logic [31:0] exp_wd;
  int          n, rdcnt;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 9'h0B4, 32'hDEADBEEF, 32'h0,        3};
    vecs[1] = '{1'b1, 1'b0, 9'h0B4, 32'h0,        32'hDEADBEEF, 2};
    vecs[2] = '{1'b0, 1'b1, 9'h000, 32'hCAFEF00D, 32'hDEADBEEF, 3};
    vecs[3] = '{1'b1, 1'b0, 9'h000, 32'h0,        32'hCAFEF00D, 2};
    vecs[4] = '{1'b1, 1'b1, 9'h123, 32'h5555AAAA, 32'hCAFEF00D, 0};
    vecs[5] = '{1'b0, 1'b1, 9'h1FF, 32'h12345678, 32'hCAFEF00D, 3};
    vecs[6] = '{1'b1, 1'b0, 9'h1FF, 32'h0,        32'h12345678, 2};
    vecs[7] = '{1'b1, 1'b0, 9'h0B4, 32'h0,        32'hDEADBEEF, 2};

    for (int i = 0; i < 512; i++) begin
      mem[i]  = 32'h0;
      mem3[i] = 32'h0;
    end
    mem[9'h1FF]  = 32'h12345678;
    mem3[9'h1FF] = 32'h12345678;

    clr = 1'b1; req_rd = 0; req_wr = 0; addr_in = '0; wdata_in = '0;
    rd3 = 0; wr3 = 0; addr3 = '0; wdata3 = '0;
    #1;
    check("reset_outputs", {rdata_out, busy, done, err, ram_read, ram_write, ram_address, ram_wdata}, 78'h0);
    @(negedge clk); clr = 1'b0;

    // Reset mid-read, no clock edge involved.
    @(negedge clk); req_rd = 1; addr_in = 9'h0B4;
    @(posedge clk); #1; req_rd = 0;
    check("busy_before_clr", {busy, ram_read}, 2'b11);
    #1 clr = 1'b1;
    #1 check("clr_async", {rdata_out, busy, done, err, ram_read, ram_write, ram_address, ram_wdata}, 78'h0);
    @(negedge clk); clr = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_after_release", {busy, ram_read, ram_write}, 3'b000);

    // Reset during the write pulse.
    @(negedge clk); req_wr = 1; addr_in = 9'h055; wdata_in = 32'hA5A5A5A5;
    @(posedge clk); #1; req_wr = 0;
    @(posedge clk); #1;
    check("wr_pulse_high", ram_write, 1'b1);
    #1 clr = 1'b1;
    #1 check("clr_mid_write", {ram_write, busy, done}, 3'b000);
    @(negedge clk); clr = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_after_clr_write", busy, 1'b0);
    exp_addr = '0;
    exp_wd   = '0;

    // Table vectors; scoreboard checks done timing and rdata_out.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_rd = vecs[i].rd; req_wr = vecs[i].wr;
      addr_in = vecs[i].addr; wdata_in = vecs[i].wdata;
      @(posedge clk); #1; req_rd = 0; req_wr = 0;
      if (vecs[i].rd && vecs[i].wr) begin
        @(negedge clk);
        check($sformatf("err_pulse_v%0d", i), {err, busy, ram_read, ram_write, ram_address, ram_wdata}, {4'b1000, exp_addr, exp_wd});
        @(negedge clk);
        check($sformatf("err_clear_v%0d", i), {err, busy, ram_read, ram_write}, 4'b0000);
      end else begin
        exp_addr = vecs[i].addr;
        if (vecs[i].wr) exp_wd = vecs[i].wdata;
        sbq.push_back('{vecs[i].exp_rdata, cyc + vecs[i].lat});
        for (int c = 0; c <= vecs[i].lat; c++) begin
          @(negedge clk);
          check($sformatf("strobe_v%0d_c%0d", i, c),
                {ram_read, ram_write, ram_address, ram_wdata},
                {vecs[i].rd && (c < vecs[i].lat), vecs[i].wr && (c == 1), exp_addr, exp_wd});
        end
        @(negedge clk);
        check($sformatf("idle_after_v%0d", i), busy, 1'b0);
        if (vecs[i].wr) check($sformatf("mem_v%0d", i), mem[vecs[i].addr], vecs[i].wdata);
      end
    end

    // Store pulse while busy with a load must be ignored.
    @(negedge clk); req_rd = 1; addr_in = 9'h1FF;
    @(posedge clk); #1; req_rd = 0;
    sbq.push_back('{32'h12345678, cyc + 2});
    @(negedge clk); req_wr = 1; addr_in = 9'h000; wdata_in = 32'hFFFFFFFF;
    @(negedge clk); req_wr = 0;
    @(negedge clk);
    @(negedge clk);
    check("busy_ign_regs", {busy, rdata_out, ram_address, ram_wdata}, {1'b0, 32'h12345678, 9'h1FF, 32'h12345678});
    repeat (2) @(negedge clk);
    check("busy_ign_mem", {busy, mem[0]}, {1'b0, 32'hCAFEF00D});

    // RD_WAIT=3 instance: done 4 edges after accept, read strobe 4 cycles.
    @(negedge clk); rd3 = 1; addr3 = 9'h1FF;
    @(posedge clk); #1; rd3 = 0;
    rdcnt = rread3 ? 1 : 0;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      n++;
      if (done3) break;
      if (rread3) rdcnt++;
    end
    check("rw3_done_edges", n, 4);
    check("rw3_read_cycles", rdcnt, 4);
    check("rw3_rdata", rdata_out3, 32'h12345678);
    @(posedge clk); #1;
    check("rw3_idle", {busy3, done3}, 2'b00);

    check("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
